// File: rtl/relu_stream_arbiter_pkg.sv
// relu_stream_arbiter_pkg
//   Shared definitions for the ReLU stream arbiter slice.
//   - Default width constants for the arbiter and its output pipe stage.
//   - Arbiter state encoding (ST_IDLE = 0, ST_BURST = 1).
//   - Round-robin index wrap helper.
package relu_stream_arbiter_pkg;

    localparam int DEF_N_REQ  = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ID_W   = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Wraps an index that can exceed n by less than n back into 0..n-1.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/relu_pipe_stage.sv
// relu_pipe_stage
//   Registered ReLU output stage shared by all requesters.
//   Ports:
//     clk, reset_n            clock, async active-low reset
//     in_valid                beat offered by the arbiter this cycle
//     in_data/in_id/in_last   signed sample, source requester, burst end
//     out_ready               downstream accept
//     out_valid/out_data/out_id/out_last  registered output beat
module relu_pipe_stage
    import relu_stream_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W   = DEF_ID_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ID_W-1:0]   in_id,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id,
    output logic              out_last
);

    logic load;

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

    // The arbiter only offers a beat when the register is free or draining,
    // so this guard never drops data; it keeps the stage safe on its own.
    assign load = in_valid & (~out_valid | out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            // A new beat replaces a draining one; valid stays high.
            out_valid <= 1'b1;
            out_data  <= relu(in_data);
            out_id    <= in_id;
            out_last  <= in_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/relu_stream_arbiter.sv
// relu_stream_arbiter
//   Round-robin burst arbiter sharing one registered ReLU stage between
//   N_REQ valid/ready activation streams; emits one tagged output stream.
//   Ports:
//     clk, reset_n                  clock, async active-low reset
//     s_valid/s_ready/s_last        per-requester handshake and burst end
//     s_data                        requester i at [i*DATA_W +: DATA_W]
//     m_valid/m_ready               output handshake
//     m_data/m_id/m_last            ReLU result, source requester, burst end
//     grant                         one-hot current grant, 0 when idle
//     busy                          burst in progress or output pending
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant; pick next valid requester from rr_ptr onwards
//   ST_BURST | requester g owns the datapath until its last beat
module relu_stream_arbiter
    import relu_stream_arbiter_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W   = DEF_ID_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        s_valid,
    output logic [N_REQ-1:0]        s_ready,
    input  logic [N_REQ*DATA_W-1:0] s_data,
    input  logic [N_REQ-1:0]        s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic [ID_W-1:0]         m_id,
    output logic                    m_last,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy
);

    arb_state_t        state;
    logic [ID_W-1:0]   g;
    logic [ID_W-1:0]   rr_ptr;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   cand;

    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              lane_open;
    logic              accept;

    // First valid requester scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'(rr_wrap(int'(rr_ptr) + k, N_REQ));
            if (!pick_found && s_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Granted lane only; other lanes never reach the datapath.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (g == ID_W'(i)) begin
                sel_data  = s_data[i*DATA_W +: DATA_W];
                sel_valid = s_valid[i];
                sel_last  = s_last[i];
            end
        end
    end

    // grant is one-hot of g throughout a burst, so it doubles as the ready mask.
    assign lane_open = (state == ST_BURST) & (~m_valid | m_ready);
    assign s_ready   = lane_open ? grant : '0;
    assign accept    = lane_open & sel_valid;
    assign busy      = (state != ST_IDLE) | m_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            g      <= '0;
            rr_ptr <= '0;
            grant  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        g     <= pick_idx;
                        grant <= N_REQ'(1) << pick_idx;
                        state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // No preemption: only the granted requester's last beat ends the burst.
                    if (accept && sel_last) begin
                        state  <= ST_IDLE;
                        grant  <= '0;
                        rr_ptr <= ID_W'(rr_wrap(int'(g) + 1, N_REQ));
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    relu_pipe_stage #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) u_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (accept),
        .in_data   (sel_data),
        .in_id     (g),
        .in_last   (sel_last),
        .out_ready (m_ready),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_id    (m_id),
        .out_last  (m_last)
    );

endmodule

// File: tb/tb_relu_stream_arbiter.sv
// tb_relu_stream_arbiter
//   Self-checking bench: per-lane source queues feed the DUT, accepted beats
//   push their expected ReLU output to a scoreboard popped on each output
//   transfer; directed checks cover arbitration order, bubbles, backpressure,
//   no-preemption and async reset.
module tb_relu_stream_arbiter;

    localparam int NR = 2;
    localparam int DW = 8;
    localparam int IW = 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } src_beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          last;
    } out_beat_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    s_valid;
    logic [NR-1:0]    s_ready;
    logic [NR*DW-1:0] s_data;
    logic [NR-1:0]    s_last;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [IW-1:0]    m_id;
    logic             m_last;
    logic [NR-1:0]    grant;
    logic             busy;

    src_beat_t src_q[NR][$];
    out_beat_t exp_q[$];
    logic [NR-1:0] src_en;
    logic [NR-1:0] acc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    relu_stream_arbiter #(
        .N_REQ  (NR),
        .DATA_W (DW),
        .ID_W   (IW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_id    (m_id),
        .m_last  (m_last),
        .grant   (grant),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
        logic signed [DW-1:0] sx;
        sx = x;
        return (sx < 0) ? '0 : x;
    endfunction

    task automatic drive_lanes();
        for (int i = 0; i < NR; i++) begin
            if (src_en[i] && src_q[i].size() > 0) begin
                s_valid[i]           = 1'b1;
                s_data[i*DW +: DW]   = src_q[i][0].data;
                s_last[i]            = src_q[i][0].last;
            end else begin
                s_valid[i]           = 1'b0;
                s_data[i*DW +: DW]   = '0;
                s_last[i]            = 1'b0;
            end
        end
    endtask

    task automatic push_beat(input int lane, input logic [DW-1:0] data, input logic last);
        src_beat_t b;
        b.data = data;
        b.last = last;
        src_q[lane].push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_grant",   32'(grant),   0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_m_data",  32'(m_data),  0);
        chk("rst_m_id",    32'(m_id),    0);
        chk("rst_m_last",  32'(m_last),  0);
        for (int i = 0; i < NR; i++) src_q[i].delete();
        exp_q.delete();
        acc    = '0;
        src_en = '1;
        drive_lanes();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag, input logic [NR-1:0] exp);
        for (int n = 0; n < 40 && grant == '0; n++) tick();
        chk(tag, 32'(grant), 32'(exp));
    endtask

    task automatic wait_clear(input string tag);
        for (int n = 0; n < 40 && grant != '0; n++) tick();
        chk(tag, 32'(grant), 0);
    endtask

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 100 && (exp_q.size() != 0 || m_valid ||
             src_q[0].size() != 0 || src_q[1].size() != 0); n++) tick();
        chk(tag, 32'(exp_q.size() + src_q[0].size() + src_q[1].size()), 0);
    endtask

    // Output scoreboard and input acceptance capture, half a cycle before the edge.
    initial begin
        out_beat_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_pending", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_data", 32'(m_data), 32'(e.data));
                        chk("sb_id",   32'(m_id),   32'(e.id));
                        chk("sb_last", 32'(m_last), 32'(e.last));
                    end
                end
                chk("sready_in_grant", 32'(s_ready & ~grant), 0);
                for (int i = 0; i < NR; i++) begin
                    acc[i] = s_valid[i] & s_ready[i];
                    if (acc[i]) begin
                        e.data = relu_ref(s_data[i*DW +: DW]);
                        e.id   = IW'(i);
                        e.last = s_last[i];
                        exp_q.push_back(e);
                    end
                end
            end else begin
                acc = '0;
            end
        end
    end

    // Source driver: retire accepted beats just after the edge, present the next.
    initial begin
        src_beat_t tmp;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
            end
            acc = '0;
            drive_lanes();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        m_ready = 1'b1;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        src_en  = '1;
        acc     = '0;
        #3;
        do_reset();

        // 1: three-beat burst from req0, negative values clamp to zero
        push_beat(0, 8'h80, 1'b0);
        push_beat(0, 8'hFF, 1'b0);
        push_beat(0, 8'd42, 1'b1);
        drive_lanes();
        tick();
        chk("t1_grant",       32'(grant),   1);
        chk("t1_bubble",      32'(m_valid), 0);
        tick();
        chk("t1_b0_valid",    32'(m_valid), 1);
        chk("t1_b0_data",     32'(m_data),  0);
        chk("t1_b0_last",     32'(m_last),  0);
        tick();
        chk("t1_b1_valid",    32'(m_valid), 1);
        chk("t1_b1_data",     32'(m_data),  0);
        tick();
        chk("t1_b2_data",     32'(m_data),  42);
        chk("t1_b2_last",     32'(m_last),  1);
        chk("t1_b2_id",       32'(m_id),    0);
        chk("t1_grant_clear", 32'(grant),   0);
        tick();
        chk("t1_drained",     32'(m_valid), 0);
        chk("t1_not_busy",    32'(busy),    0);
        wait_drain("t1_drain");

        // 2: both valid after reset, round-robin and pointer wrap
        do_reset();
        push_beat(0, 8'd5, 1'b0);
        push_beat(0, 8'd6, 1'b1);
        push_beat(1, 8'd7, 1'b0);
        push_beat(1, 8'hFD, 1'b1);
        drive_lanes();
        wait_grant("t2_first_req0", 2'b01);
        wait_clear("t2_first_done");
        wait_grant("t2_second_req1", 2'b10);
        wait_clear("t2_second_done");
        push_beat(0, 8'd9, 1'b1);
        push_beat(1, 8'd10, 1'b1);
        drive_lanes();
        wait_grant("t2_wrap_req0", 2'b01);
        wait_clear("t2_wrap_done");
        wait_grant("t2_wrap_req1", 2'b10);
        wait_clear("t2_wrap_req1_done");
        wait_drain("t2_drain");

        // 3: backpressure on req1's burst
        push_beat(1, 8'd1, 1'b0);
        push_beat(1, 8'd127, 1'b1);
        drive_lanes();
        wait_grant("t3_grant", 2'b10);
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_valid", 32'(m_valid),    1);
            chk("t3_hold_data",  32'(m_data),     1);
            chk("t3_hold_ready", 32'(s_ready[1]), 0);
        end
        m_ready = 1'b1;
        tick();
        chk("t3_next_valid", 32'(m_valid), 1);
        chk("t3_next_data",  32'(m_data),  127);
        chk("t3_next_last",  32'(m_last),  1);
        wait_clear("t3_done");
        wait_drain("t3_drain");

        // 4: req0 stalls mid-burst, req1 must keep waiting
        push_beat(0, 8'd3, 1'b0);
        push_beat(0, 8'd4, 1'b0);
        push_beat(0, 8'd8, 1'b1);
        push_beat(1, 8'd11, 1'b1);
        drive_lanes();
        wait_grant("t4_grant", 2'b01);
        tick();
        src_en[0] = 1'b0;
        drive_lanes();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_hold_grant",  32'(grant),      1);
            chk("t4_req1_ready",  32'(s_ready[1]), 0);
        end
        src_en[0] = 1'b1;
        drive_lanes();
        wait_clear("t4_req0_done");
        wait_grant("t4_req1_after", 2'b10);
        wait_clear("t4_req1_done");
        wait_drain("t4_drain");

        // 5: async reset mid-burst with an output beat pending
        push_beat(0, 8'd20, 1'b0);
        push_beat(0, 8'd21, 1'b0);
        push_beat(0, 8'd22, 1'b1);
        drive_lanes();
        wait_grant("t5_grant", 2'b01);
        tick();
        chk("t5_pre_valid", 32'(m_valid), 1);
        do_reset();
        push_beat(1, 8'd2, 1'b1);
        drive_lanes();
        wait_grant("t5_after_req1", 2'b10);
        tick();
        chk("t5_data", 32'(m_data), 2);
        chk("t5_id",   32'(m_id),   1);
        chk("t5_last", 32'(m_last), 1);
        wait_drain("t5_drain");

        // 6: alternating single-beat bursts with one idle cycle between grants
        push_beat(0, 8'd0, 1'b1);
        push_beat(1, 8'hFB, 1'b1);
        drive_lanes();
        wait_grant("t6_grant0", 2'b01);
        tick();
        chk("t6_bubble_grant", 32'(grant),   0);
        chk("t6_o0_valid",     32'(m_valid), 1);
        chk("t6_o0_data",      32'(m_data),  0);
        chk("t6_o0_id",        32'(m_id),    0);
        chk("t6_o0_last",      32'(m_last),  1);
        tick();
        chk("t6_grant1",       32'(grant),   2);
        tick();
        chk("t6_o1_valid",     32'(m_valid), 1);
        chk("t6_o1_data",      32'(m_data),  0);
        chk("t6_o1_id",        32'(m_id),    1);
        chk("t6_o1_last",      32'(m_last),  1);
        chk("t6_grant_clear",  32'(grant),   0);
        wait_drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
